// File: rtl/hpdcache_sram_req_adapter_if.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_sram_req_adapter_if
//  Purpose  : Request / response / 1RW-SRAM bundle for the SRAM request adapter.
//  Revision : 1.0
// ============================================================================
interface hpdcache_sram_req_adapter_if #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 64
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_SIZE-1:0]   req_addr;
    logic [DATA_SIZE-1:0]   req_wdata;
    logic [DATA_SIZE/8-1:0] req_be;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_SIZE-1:0]   rsp_rdata;

    logic                   sram_cs;
    logic                   sram_we;
    logic [ADDR_SIZE-1:0]   sram_addr;
    logic [DATA_SIZE-1:0]   sram_wdata;
    logic [DATA_SIZE/8-1:0] sram_wbyteenable;
    logic [DATA_SIZE-1:0]   sram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable
    );
endinterface
`default_nettype wire

// File: rtl/hpdcache_sram_req_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_sram_req_adapter
//  Purpose  : Valid/ready front-end for a 1RW byte-enable SRAM with a 2-entry
//             read response FIFO. HPDCACHE_SRAM_INIT_EN adds a zero-fill pass.
//  Revision : 1.0
// ============================================================================
module hpdcache_sram_req_adapter #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 2**ADDR_SIZE
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    hpdcache_sram_req_adapter_if.slave  bus
);
    localparam int BE_SIZE = DATA_SIZE / 8;

    if (DEPTH > (1 << ADDR_SIZE)) begin : g_depth_check
        $error("DEPTH exceeds the SRAM address space");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   fifo_q [2];
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             count_q, count_d;
    logic                   rd_pending_q;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_rd_room;
    logic                   w_accept;
    logic                   w_req_ready;
    logic                   w_sram_cs;
    logic                   w_sram_we;
    logic [ADDR_SIZE-1:0]   w_sram_addr;
    logic [DATA_SIZE-1:0]   w_sram_wdata;
    logic [BE_SIZE-1:0]     w_sram_be;

`ifdef HPDCACHE_SRAM_INIT_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
    logic [ADDR_SIZE-1:0]   init_cnt_q, init_cnt_d;
`endif

    // rd_pending covers the SRAM's one cycle of read latency; its data lands
    // in the FIFO at the end of that cycle, so it already counts as occupancy.
    assign w_push    = rd_pending_q;
    assign w_pop     = (count_q != 2'd0) & bus.rsp_ready;
    assign w_rd_room = (({1'b0, count_q} + {2'b00, rd_pending_q}) - {2'b00, w_pop}) < 3'd2;
    assign count_d   = (count_q + {1'b0, w_push}) - {1'b0, w_pop};

    always_comb begin
        state_d      = state_q;
        w_req_ready  = 1'b0;
        w_accept     = 1'b0;
        w_sram_cs    = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        w_sram_be    = '0;
`ifdef HPDCACHE_SRAM_INIT_EN
        init_cnt_d   = init_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef HPDCACHE_SRAM_INIT_EN
                state_d = INIT;
`else
                state_d = RUN;
`endif
            end
`ifdef HPDCACHE_SRAM_INIT_EN
            INIT: begin
                w_sram_cs   = 1'b1;
                w_sram_we   = 1'b1;
                w_sram_addr = init_cnt_q;
                w_sram_be   = '1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
`endif
            RUN: begin
                w_req_ready = bus.req_we | w_rd_room;
                w_accept    = bus.req_valid & w_req_ready;
                if (w_accept) begin
                    w_sram_cs   = 1'b1;
                    w_sram_we   = bus.req_we;
                    w_sram_addr = bus.req_addr;
                    if (bus.req_we) begin
                        w_sram_wdata = bus.req_wdata;
                        w_sram_be    = bus.req_be;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_pending_q <= 1'b0;
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= w_accept & ~bus.req_we;
            count_q      <= count_d;
            if (w_push) begin
                fifo_q[wr_ptr_q] <= bus.sram_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

`ifdef HPDCACHE_SRAM_INIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end
`endif

    assign bus.req_ready        = w_req_ready;
    assign bus.rsp_valid        = (count_q != 2'd0);
    assign bus.rsp_rdata        = fifo_q[rd_ptr_q];
    assign bus.sram_cs          = w_sram_cs;
    assign bus.sram_we          = w_sram_we;
    assign bus.sram_addr        = w_sram_addr;
    assign bus.sram_wdata       = w_sram_wdata;
    assign bus.sram_wbyteenable = w_sram_be;

endmodule
`default_nettype wire
